wb_ingress: RTL and testbench



---
 rtl/wb_ingress_if.sv | 37 +++
 rtl/wb_ingress.sv | 138 +++++++++++++
 tb/tb_wb_ingress.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_ingress_if.sv
// Wishbone B4 bus bundle with tag signals.
// Slave side samples requests and returns registered ACK/ERR.
interface wishbone_if #(
  parameter int ADR_W = 32,
  parameter int DAT_W = 32,
  parameter int SEL_W = 4,
  parameter int TGA_W = 8,
  parameter int TGD_W = 8,
  parameter int TGC_W = 4,
  parameter int CTI_W = 3
);
  logic             CYC;
  logic             STB;
  logic             WE;
  logic [ADR_W-1:0] ADR;
  logic [SEL_W-1:0] SEL;
  logic [DAT_W-1:0] DAT_I;
  logic [TGA_W-1:0] TGA;
  logic [TGD_W-1:0] TGD_I;
  logic [TGC_W-1:0] TGC;
  logic [CTI_W-1:0] CTI;
  logic [1:0]       BTE;
  logic             ACK;
  logic             ERR;

  modport slave (
    input  CYC, STB, WE, ADR, SEL, DAT_I,
    input  TGA, TGD_I, TGC, CTI, BTE,
    output ACK, ERR
  );

  modport master (
    output CYC, STB, WE, ADR, SEL, DAT_I,
    output TGA, TGD_I, TGC, CTI, BTE,
    input  ACK, ERR
  );
endinterface

// File: rtl/wb_ingress.sv
// Write-only Wishbone slave that packs beats into AXI-style
// address and data FIFO entries.
module wb_ingress #(
  parameter int WB_ADR_W   = 32,
  parameter int WB_DAT_W   = 32,
  parameter int WB_TGA_W   = 8,
  parameter int WB_TGD_W   = 8,
  parameter int WB_TGC_W   = 4,
  parameter int WB_SEL_W   = 4,
  parameter int WB_CTI_W   = 3,
  parameter int AXI_ID_W   = 3,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_LEN_W  = 4,
  parameter int AXI_STB_W  = 4,
  localparam int FIFO_ADR_W =
    AXI_ID_W + AXI_ADDR_W + AXI_LEN_W + 11 + WB_TGC_W,
  localparam int FIFO_DAT_W =
    AXI_ID_W + WB_DAT_W + AXI_STB_W + 2
) (
  input  logic                  wb_clk,
  input  logic                  wb_reset,
  input  logic                  ENABLE,
  wishbone_if.slave             WB_RX_IF,
  output logic [FIFO_ADR_W-1:0] fifo_adr_wdata,
  output logic                  fifo_adr_wr,
  input  logic                  fifo_adr_full,
  output logic [FIFO_DAT_W-1:0] fifo_dat_wdata,
  output logic                  fifo_dat_wr,
  input  logic                  fifo_dat_full
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_WAIT
  } state_t;

  state_t                r_state;
  logic [AXI_LEN_W-1:0]  r_cnt;
  logic                  r_ack;
  logic                  r_err;
  logic                  r_ready;
  logic                  r_burst;
  logic [AXI_ID_W-1:0]   r_id;
  logic [AXI_ADDR_W-1:0] r_addr;
  logic [WB_TGC_W-1:0]   r_cache;

  logic                  w_req;
  logic                  w_close;
  logic                  w_busy;
  logic                  w_open;
  logic                  w_acc;
  logic                  w_rd;
  logic                  w_first;
  logic [AXI_ID_W-1:0]   w_id;
  logic [AXI_ADDR_W-1:0] w_addr;
  logic [WB_TGC_W-1:0]   w_cache;
  logic                  w_unused;

  // Only CTI=010 keeps a burst open; every other code closes the beat.
  always_comb begin
    w_req   = WB_RX_IF.CYC & WB_RX_IF.STB;
    w_close = (WB_RX_IF.CTI != 3'b010) | (&r_cnt);
    w_busy  = !r_ready | r_err | (r_ack & !r_burst);
    w_open  = (r_state != ST_IDLE) | ENABLE;
    w_acc   = w_req & WB_RX_IF.WE & !w_busy & w_open &
              !fifo_dat_full & !(fifo_adr_full & w_close);
    w_rd    = w_req & !WB_RX_IF.WE & !w_busy;
    w_first = (r_state == ST_IDLE);
    w_id    = w_first ? WB_RX_IF.TGA[AXI_ID_W-1:0] : r_id;
    w_addr  = w_first ? {WB_RX_IF.ADR[WB_ADR_W-1:2], 2'b00}
                      : r_addr;
    w_cache = w_first ? WB_RX_IF.TGC : r_cache;
  end

  assign w_unused = ^{WB_RX_IF.BTE,
                      WB_RX_IF.TGA[WB_TGA_W-1:AXI_ID_W],
                      WB_RX_IF.TGD_I[WB_TGD_W-1:AXI_ID_W],
                      WB_RX_IF.ADR[1:0]};

  assign WB_RX_IF.ACK = r_ack;
  assign WB_RX_IF.ERR = r_err;

  always_ff @(posedge wb_clk) begin
    if (wb_reset) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_ack          <= 1'b0;
      r_err          <= 1'b0;
      r_ready        <= 1'b0;
      r_burst        <= 1'b0;
      r_id           <= '0;
      r_addr         <= '0;
      r_cache        <= '0;
      fifo_adr_wdata <= '0;
      fifo_adr_wr    <= 1'b0;
      fifo_dat_wdata <= '0;
      fifo_dat_wr    <= 1'b0;
    end else begin
      r_ready     <= 1'b1;
      r_ack       <= w_acc;
      r_err       <= w_rd;
      fifo_dat_wr <= w_acc;
      fifo_adr_wr <= w_acc & w_close;
      if (w_acc) begin
        r_burst        <= !w_close;
        r_id           <= w_id;
        r_addr         <= w_addr;
        r_cache        <= w_cache;
        fifo_dat_wdata <= {WB_RX_IF.TGD_I[AXI_ID_W-1:0],
                           WB_RX_IF.DAT_I, WB_RX_IF.SEL,
                           w_close, 1'b1};
        if (w_close) begin
          fifo_adr_wdata <= {w_id, w_addr, r_cnt, 3'b010,
                             2'b01, 2'b00, w_cache,
                             3'b000, 1'b1};
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      unique case (r_state)
        ST_IDLE: begin
          if (w_acc && !w_close) r_state <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (w_acc && w_close) r_state <= ST_IDLE;
          else if (!WB_RX_IF.CYC) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_acc) r_state <= w_close ? ST_IDLE : ST_ACTIVE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ingress.sv
// Scoreboard bench for wb_ingress: directed Wishbone writes,
// expected FIFO entries queued at issue and checked on push.
module tb_wb_ingress;

  logic        clk;
  logic        rst;
  logic        en;
  logic        adr_full;
  logic        dat_full;
  logic [53:0] adr_wdata;
  logic        adr_wr;
  logic [40:0] dat_wdata;
  logic        dat_wr;

  wishbone_if wb ();

  wb_ingress dut (
    .wb_clk        (clk),
    .wb_reset      (rst),
    .ENABLE        (en),
    .WB_RX_IF      (wb.slave),
    .fifo_adr_wdata(adr_wdata),
    .fifo_adr_wr   (adr_wr),
    .fifo_adr_full (adr_full),
    .fifo_dat_wdata(dat_wdata),
    .fifo_dat_wr   (dat_wr),
    .fifo_dat_full (dat_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] ID    = 3'd5;
  localparam logic [2:0] WID   = 3'd3;
  localparam logic [3:0] CACHE = 4'hA;

  int n_chk = 0;
  int n_fail = 0;
  int err_seen = 0;
  int ack_cnt = 0;

  logic [40:0] exp_dat[$];
  logic [53:0] exp_adr[$];
  logic [53:0] adr_log[$];

  int          m_cnt = 0;
  logic [2:0]  m_id;
  logic [31:0] m_addr;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT pushes.
  always @(negedge clk) begin
    if (wb.ACK && wb.ERR) chk("ack_err_excl", 1, 0);
    if (wb.ACK || dat_wr) chk("ack_vs_push", wb.ACK, dat_wr);
    if (wb.ERR) err_seen++;
    if (dat_wr) begin
      if (exp_dat.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL dat_unexpected: got %0h", dat_wdata);
      end else begin
        chk("dat_entry", dat_wdata, exp_dat.pop_front());
      end
    end
    if (adr_wr) begin
      adr_log.push_back(adr_wdata);
      if (exp_adr.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL adr_unexpected: got %0h", adr_wdata);
      end else begin
        chk("adr_entry", adr_wdata, exp_adr.pop_front());
      end
    end
  end

  // Master: n beats from address a; rst_after aborts with reset.
  task automatic wb_xfer(input logic [31:0] a, input int n,
                         input bit classic, input int rst_after,
                         input logic [31:0] d0,
                         output int lat, output int span);
    int acks, cyc, first, w;
    bit close;
    acks = 0; cyc = 0; first = -1; lat = -1; span = -1;
    for (int i = 0; i < n; i++) begin
      close = classic || (i == n - 1) || (m_cnt == 15);
      wb.CYC   = 1'b1;
      wb.STB   = 1'b1;
      wb.WE    = 1'b1;
      wb.ADR   = a + 32'(4 * i);
      wb.DAT_I = d0 + 32'(i);
      wb.SEL   = 4'hF;
      wb.TGA   = {5'h1B, ID};
      wb.TGD_I = {5'h11, WID};
      wb.TGC   = CACHE;
      wb.CTI   = classic ? 3'b000 :
                 (i == n - 1) ? 3'b111 : 3'b010;
      if (m_cnt == 0) begin
        m_id   = ID;
        m_addr = {wb.ADR[31:2], 2'b00};
      end
      exp_dat.push_back({WID, wb.DAT_I, 4'hF, close, 1'b1});
      if (close) begin
        exp_adr.push_back({m_id, m_addr, 4'(m_cnt), 3'b010,
                           2'b01, 2'b00, CACHE, 3'b000, 1'b1});
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
      w = 0;
      do begin
        @(posedge clk); #1;
        cyc++; w++;
      end while (!wb.ACK && w < 60);
      if (!wb.ACK) begin
        chk("ack_timeout", 0, 1);
        break;
      end
      if (first < 0) begin
        first = cyc;
        lat = cyc;
      end
      span = cyc - first;
      acks++;
      ack_cnt++;
      if (acks == rst_after) begin
        rst = 1'b1;
        m_cnt = 0;
        break;
      end
    end
    wb.CYC = 1'b0;
    wb.STB = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int lat, span, base, k;

  initial begin
    rst = 1'b1; en = 1'b1; adr_full = 1'b0; dat_full = 1'b0;
    wb.CYC = 0; wb.STB = 0; wb.WE = 0; wb.ADR = '0;
    wb.SEL = '0; wb.DAT_I = '0; wb.TGA = '0; wb.TGD_I = '0;
    wb.TGC = '0; wb.CTI = '0; wb.BTE = 2'b01;
    idle(3);
    chk("rst_ack", wb.ACK, 0);
    chk("rst_err", wb.ERR, 0);
    chk("rst_dat_wr", dat_wr, 0);
    chk("rst_adr_wr", adr_wr, 0);
    chk("rst_dat_wdata", dat_wdata, 0);
    chk("rst_adr_wdata", adr_wdata, 0);
    rst = 1'b0;

    // Classic single right after reset release
    adr_log.delete();
    wb_xfer(32'h1000_0006, 1, 1, 0, 32'hA5A5_5A5A, lat, span);
    chk("release_latency", lat, 2);
    idle(2);
    chk("classic_adr_pushes", adr_log.size(), 1);
    if (adr_log.size() > 0) begin
      chk("classic_addr", adr_log[0][50:19], 32'h1000_0004);
      chk("classic_len", adr_log[0][18:15], 0);
    end

    // Read cycle answered with a single ERR
    wb.CYC = 1; wb.STB = 1; wb.WE = 0; wb.ADR = 32'h40;
    idle(1);
    chk("read_err", wb.ERR, 1);
    chk("read_ack", wb.ACK, 0);
    wb.CYC = 0; wb.STB = 0;
    idle(1);
    chk("read_err_drop", wb.ERR, 0);
    idle(1);

    // ENABLE low holds off a new transaction
    en = 1'b0;
    fork
      wb_xfer(32'h0000_0100, 1, 1, 0, 32'h1111_0000, lat, span);
      begin
        repeat (4) @(posedge clk);
        #1 en = 1'b1;
      end
    join
    chk("enable_latency", lat, 5);
    idle(2);

    // INCR burst of 4
    adr_log.delete();
    wb_xfer(32'h0000_2000, 4, 0, 0, 32'h2222_0000, lat, span);
    chk("incr4_span", span, 3);
    idle(2);
    chk("incr4_adr_pushes", adr_log.size(), 1);
    if (adr_log.size() > 0) begin
      chk("incr4_addr", adr_log[0][50:19], 32'h2000);
      chk("incr4_len", adr_log[0][18:15], 3);
    end

    // Two classic singles under one CYC keep an idle gap
    wb_xfer(32'h0000_3000, 2, 1, 0, 32'h3333_0000, lat, span);
    chk("classic_gap_span", span, 2);
    idle(2);

    // 20-beat burst splits at 16
    adr_log.delete();
    wb_xfer(32'h0000_0000, 20, 0, 0, 32'h4444_0000, lat, span);
    idle(2);
    chk("long_adr_pushes", adr_log.size(), 2);
    if (adr_log.size() > 1) begin
      chk("long0_addr", adr_log[0][50:19], 32'h0);
      chk("long0_len", adr_log[0][18:15], 15);
      chk("long1_addr", adr_log[1][50:19], 32'h40);
      chk("long1_len", adr_log[1][18:15], 3);
    end

    // Data FIFO full for 5 cycles mid-burst
    base = ack_cnt;
    fork
      wb_xfer(32'h0000_6000, 8, 0, 0, 32'h6666_0000, lat, span);
      begin
        k = 0;
        while (ack_cnt < base + 3 && k < 2000) begin
          #1; k++;
        end
        if (ack_cnt < base + 3) begin
          chk("stall_start_timeout", 0, 1);
        end else begin
          dat_full = 1'b1;
          repeat (5) begin
            @(posedge clk); #1;
            chk("stall_ack", wb.ACK, 0);
            chk("stall_push", dat_wr, 0);
          end
          dat_full = 1'b0;
        end
      end
    join
    idle(2);

    // Reset after beat 2 of an 8-beat burst
    adr_log.delete();
    wb_xfer(32'h0000_7000, 8, 0, 2, 32'h7777_0000, lat, span);
    idle(1);
    chk("rstmid_ack", wb.ACK, 0);
    chk("rstmid_dat_wr", dat_wr, 0);
    chk("rstmid_adr_wr", adr_wr, 0);
    chk("rstmid_dat_wdata", dat_wdata, 0);
    idle(1);
    rst = 1'b0;
    wb_xfer(32'h0000_8000, 2, 0, 0, 32'h8888_0000, lat, span);
    chk("rstmid_release_lat", lat, 2);
    idle(2);
    chk("rstmid_adr_pushes", adr_log.size(), 1);
    if (adr_log.size() > 0) begin
      chk("rstmid_addr", adr_log[0][50:19], 32'h8000);
      chk("rstmid_len", adr_log[0][18:15], 1);
    end

    idle(3);
    chk("dat_queue_drained", exp_dat.size(), 0);
    chk("adr_queue_drained", exp_adr.size(), 0);
    chk("err_count", err_seen, 1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
